// File: rtl/cpu6502_bus_responder.sv
// 6502 bus responder: internal zero/stack-page RAM plus external
// request/acknowledge forwarding, pacing the CPU via cpuEnable.
module cpu6502_bus_responder #(
    parameter int INTERNAL_RAM   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        runEnable,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataOut,
    input  logic        cpuWriteEnable,
    output logic [7:0]  cpuDataIn,
    output logic        cpuEnable,
    output logic        extRequest,
    output logic [15:0] extAddress,
    output logic [7:0]  extWriteData,
    output logic        extWriteEnable,
    input  logic        extAcknowledge,
    input  logic [7:0]  extReadData,
    output logic        busError,
    input  logic        busErrorClear
);

    typedef enum logic [1:0] {
        START,
        EXT_WAIT,
        COMPLETE
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam bit         TIMEOUT_ON    = (TIMEOUT_CYCLES != 0);

    state_t     state;
    logic [7:0] counter;
    logic [7:0] ramData;
    logic       internalHit;
    logic       timeoutHit;

    assign internalHit = (INTERNAL_RAM != 0) && (cpuAddress[15:9] == 7'd0);
    assign timeoutHit  = TIMEOUT_ON && (counter == TIMEOUT_LIMIT);

    // RAM deliberately has no reset so its contents survive nReset.
    if (INTERNAL_RAM != 0) begin : gRam
        logic [7:0] ram [512];
        logic       ramWrite;

        assign ramWrite = (state == START) && runEnable
                       && internalHit && cpuWriteEnable;

        always_ff @(posedge clock) begin
            if (ramWrite) begin
                ram[cpuAddress[8:0]] <= cpuDataOut;
            end
        end

        assign ramData = ram[cpuAddress[8:0]];
    end else begin : gNoRam
        assign ramData = 8'h00;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state          <= START;
            counter        <= 8'h00;
            cpuDataIn      <= 8'h00;
            cpuEnable      <= 1'b0;
            extRequest     <= 1'b0;
            extAddress     <= 16'h0000;
            extWriteData   <= 8'h00;
            extWriteEnable <= 1'b0;
            busError       <= 1'b0;
        end else begin
            cpuEnable <= 1'b0;
            if (busErrorClear) begin
                busError <= 1'b0;
            end
            unique case (state)
                START: begin
                    if (runEnable) begin
                        if (internalHit) begin
                            cpuDataIn <= cpuWriteEnable ? cpuDataOut : ramData;
                            cpuEnable <= 1'b1;
                            state     <= COMPLETE;
                        end else begin
                            extAddress     <= cpuAddress;
                            extWriteData   <= cpuDataOut;
                            extWriteEnable <= cpuWriteEnable;
                            extRequest     <= 1'b1;
                            counter        <= 8'h00;
                            state          <= EXT_WAIT;
                        end
                    end
                end
                EXT_WAIT: begin
                    if (extAcknowledge) begin
                        cpuDataIn      <= extWriteEnable ? extWriteData
                                                         : extReadData;
                        extRequest     <= 1'b0;
                        extWriteEnable <= 1'b0;
                        cpuEnable      <= 1'b1;
                        state          <= COMPLETE;
                    end else if (timeoutHit) begin
                        // Open bus: high address byte floats back.
                        cpuDataIn      <= extAddress[15:8];
                        extRequest     <= 1'b0;
                        extWriteEnable <= 1'b0;
                        busError       <= 1'b1;
                        cpuEnable      <= 1'b1;
                        state          <= COMPLETE;
                    end else begin
                        counter <= counter + 8'h01;
                    end
                end
                COMPLETE: begin
                    state <= START;
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6502_bus_responder.sv
// Directed bench for cpu6502_bus_responder: internal RAM, external
// latency, timeout, external-only variant, halt and reset abort.
module tb_cpu6502_bus_responder;

    logic        clock = 1'b0;
    logic        nReset;
    logic        runEnable;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDataOut;
    logic        cpuWriteEnable;
    logic [7:0]  cpuDataIn;
    logic        cpuEnable;
    logic        extRequest;
    logic [15:0] extAddress;
    logic [7:0]  extWriteData;
    logic        extWriteEnable;
    logic        extAcknowledge;
    logic [7:0]  extReadData;
    logic        busError;
    logic        busErrorClear;

    logic        bRun;
    logic [7:0]  bDataIn;
    logic        bEnable;
    logic        bRequest;
    logic [15:0] bAddress;
    logic [7:0]  bWriteData;
    logic        bWriteEnable;
    logic        bAck;
    logic [7:0]  bReadData;
    logic        bError;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    cpu6502_bus_responder #(
        .INTERNAL_RAM(1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clock),
        .nReset(nReset),
        .runEnable(runEnable),
        .cpuAddress(cpuAddress),
        .cpuDataOut(cpuDataOut),
        .cpuWriteEnable(cpuWriteEnable),
        .cpuDataIn(cpuDataIn),
        .cpuEnable(cpuEnable),
        .extRequest(extRequest),
        .extAddress(extAddress),
        .extWriteData(extWriteData),
        .extWriteEnable(extWriteEnable),
        .extAcknowledge(extAcknowledge),
        .extReadData(extReadData),
        .busError(busError),
        .busErrorClear(busErrorClear)
    );

    cpu6502_bus_responder #(
        .INTERNAL_RAM(0),
        .TIMEOUT_CYCLES(255)
    ) dutExt (
        .clock(clock),
        .nReset(nReset),
        .runEnable(bRun),
        .cpuAddress(cpuAddress),
        .cpuDataOut(cpuDataOut),
        .cpuWriteEnable(cpuWriteEnable),
        .cpuDataIn(bDataIn),
        .cpuEnable(bEnable),
        .extRequest(bRequest),
        .extAddress(bAddress),
        .extWriteData(bWriteData),
        .extWriteEnable(bWriteEnable),
        .extAcknowledge(bAck),
        .extReadData(bReadData),
        .busError(bError),
        .busErrorClear(busErrorClear)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        runEnable = 1'b0;
        cpuAddress = 16'h0000;
        cpuDataOut = 8'h00;
        cpuWriteEnable = 1'b0;
        extAcknowledge = 1'b0;
        extReadData = 8'h00;
        busErrorClear = 1'b0;
        bRun = 1'b0;
        bAck = 1'b0;
        bReadData = 8'h00;
        repeat (3) tick();
        vectors++;
        if ({cpuEnable, cpuDataIn, extRequest, extAddress,
             extWriteData, extWriteEnable, busError} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_state en=%b din=%h req=%b addr=%h wd=%h we=%b err=%b want all 0",
                     cpuEnable, cpuDataIn, extRequest, extAddress,
                     extWriteData, extWriteEnable, busError);
        end
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_internal();
        // write 5A to 01FF
        runEnable = 1'b1;
        cpuAddress = 16'h01FF;
        cpuDataOut = 8'h5A;
        cpuWriteEnable = 1'b1;
        tick();
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h5A || extRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL int_write en=%b din=%h req=%b want 1/5a/0",
                     cpuEnable, cpuDataIn, extRequest);
        end
        cpuAddress = 16'h0000;
        cpuDataOut = 8'h33;
        tick();
        vectors++;
        if (cpuEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL int_start_en got=%b want 0", cpuEnable);
        end
        tick();
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h33) begin
            miscompares++;
            $display("FAIL int_write2 en=%b din=%h want 1/33", cpuEnable, cpuDataIn);
        end
        cpuAddress = 16'h01FF;
        cpuDataOut = 8'hEE;
        cpuWriteEnable = 1'b0;
        tick();
        tick();
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h5A || extRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL int_read_1ff en=%b din=%h req=%b want 1/5a/0",
                     cpuEnable, cpuDataIn, extRequest);
        end
        cpuAddress = 16'h0000;
        tick();
        tick();
        runEnable = 1'b0;
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h33) begin
            miscompares++;
            $display("FAIL int_read_000 en=%b din=%h want 1/33", cpuEnable, cpuDataIn);
        end
        tick();
    endtask

    task automatic test_external_read();
        runEnable = 1'b1;
        cpuAddress = 16'h8000;
        cpuWriteEnable = 1'b0;
        tick();
        runEnable = 1'b0;
        cpuAddress = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (extRequest !== 1'b1 || extAddress !== 16'h8000 || cpuEnable !== 1'b0) begin
                miscompares++;
                $display("FAIL ext_wait%0d req=%b addr=%h en=%b want 1/8000/0",
                         i, extRequest, extAddress, cpuEnable);
            end
            if (i == 2) begin
                extAcknowledge = 1'b1;
                extReadData = 8'hC3;
            end
            tick();
        end
        extAcknowledge = 1'b0;
        extReadData = 8'h00;
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'hC3 || extRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_read_done en=%b din=%h req=%b want 1/c3/0",
                     cpuEnable, cpuDataIn, extRequest);
        end
        tick();
        vectors++;
        if (cpuEnable !== 1'b0 || cpuDataIn !== 8'hC3) begin
            miscompares++;
            $display("FAIL ext_read_hold en=%b din=%h want 0/c3", cpuEnable, cpuDataIn);
        end
    endtask

    task automatic test_external_write();
        runEnable = 1'b1;
        cpuAddress = 16'h4000;
        cpuDataOut = 8'h99;
        cpuWriteEnable = 1'b1;
        tick();
        runEnable = 1'b0;
        cpuWriteEnable = 1'b0;
        vectors++;
        if (extRequest !== 1'b1 || extWriteEnable !== 1'b1 ||
            extWriteData !== 8'h99 || extAddress !== 16'h4000) begin
            miscompares++;
            $display("FAIL ext_write_req req=%b we=%b wd=%h addr=%h want 1/1/99/4000",
                     extRequest, extWriteEnable, extWriteData, extAddress);
        end
        extAcknowledge = 1'b1;
        extReadData = 8'h11;
        tick();
        extAcknowledge = 1'b0;
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h99 ||
            extWriteEnable !== 1'b0 || extRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_write_done en=%b din=%h we=%b req=%b want 1/99/0/0",
                     cpuEnable, cpuDataIn, extWriteEnable, extRequest);
        end
        tick();
    endtask

    task automatic test_timeout();
        runEnable = 1'b1;
        cpuAddress = 16'hD012;
        cpuWriteEnable = 1'b0;
        tick();
        runEnable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (extRequest !== 1'b1 || cpuEnable !== 1'b0 || busError !== 1'b0) begin
                miscompares++;
                $display("FAIL tmo_wait%0d req=%b en=%b err=%b want 1/0/0",
                         i, extRequest, cpuEnable, busError);
            end
        end
        tick();
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'hD0 ||
            busError !== 1'b1 || extRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_done en=%b din=%h err=%b req=%b want 1/d0/1/0",
                     cpuEnable, cpuDataIn, busError, extRequest);
        end
        repeat (3) tick();
        vectors++;
        if (busError !== 1'b1 || extRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_sticky err=%b req=%b want 1/0", busError, extRequest);
        end
        busErrorClear = 1'b1;
        tick();
        busErrorClear = 1'b0;
        vectors++;
        if (busError !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_clear err=%b want 0", busError);
        end
        // ack lands on the cycle that would otherwise time out
        runEnable = 1'b1;
        tick();
        runEnable = 1'b0;
        repeat (4) tick();
        extAcknowledge = 1'b1;
        extReadData = 8'h77;
        tick();
        extAcknowledge = 1'b0;
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h77 || busError !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_ack_race en=%b din=%h err=%b want 1/77/0",
                     cpuEnable, cpuDataIn, busError);
        end
        tick();
    endtask

    task automatic test_external_only();
        bRun = 1'b1;
        cpuAddress = 16'h0010;
        cpuWriteEnable = 1'b0;
        tick();
        bRun = 1'b0;
        vectors++;
        if (bRequest !== 1'b1 || bAddress !== 16'h0010 || bEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL noram_req req=%b addr=%h en=%b want 1/0010/0",
                     bRequest, bAddress, bEnable);
        end
        bAck = 1'b1;
        bReadData = 8'h42;
        tick();
        bAck = 1'b0;
        vectors++;
        if (bEnable !== 1'b1 || bDataIn !== 8'h42 || bRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL noram_done en=%b din=%h req=%b want 1/42/0",
                     bEnable, bDataIn, bRequest);
        end
        tick();
    endtask

    task automatic test_halt();
        runEnable = 1'b1;
        cpuAddress = 16'h9000;
        cpuWriteEnable = 1'b0;
        tick();
        runEnable = 1'b0;
        cpuAddress = 16'h01FF;
        tick();
        extAcknowledge = 1'b1;
        extReadData = 8'h3C;
        tick();
        extAcknowledge = 1'b0;
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h3C) begin
            miscompares++;
            $display("FAIL halt_complete en=%b din=%h want 1/3c", cpuEnable, cpuDataIn);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (cpuEnable !== 1'b0 || extRequest !== 1'b0 || cpuDataIn !== 8'h3C) begin
                miscompares++;
                $display("FAIL halt_idle%0d en=%b req=%b din=%h want 0/0/3c",
                         i, cpuEnable, extRequest, cpuDataIn);
            end
        end
        runEnable = 1'b1;
        tick();
        runEnable = 1'b0;
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h5A) begin
            miscompares++;
            $display("FAIL halt_resume en=%b din=%h want 1/5a", cpuEnable, cpuDataIn);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        runEnable = 1'b1;
        cpuAddress = 16'hA000;
        cpuDataOut = 8'h11;
        cpuWriteEnable = 1'b1;
        tick();
        runEnable = 1'b0;
        cpuWriteEnable = 1'b0;
        vectors++;
        if (extRequest !== 1'b1 || extWriteEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre req=%b we=%b want 1/1", extRequest, extWriteEnable);
        end
        #2;
        nReset = 1'b0;
        #1;
        vectors++;
        if ({cpuEnable, cpuDataIn, extRequest, extAddress,
             extWriteData, extWriteEnable, busError} !== 36'h0) begin
            miscompares++;
            $display("FAIL rst_async en=%b din=%h req=%b addr=%h wd=%h we=%b err=%b want all 0",
                     cpuEnable, cpuDataIn, extRequest, extAddress,
                     extWriteData, extWriteEnable, busError);
        end
        repeat (2) @(posedge clock);
        #2;
        nReset = 1'b1;
        runEnable = 1'b1;
        cpuAddress = 16'h01FF;
        tick();
        runEnable = 1'b0;
        vectors++;
        if (cpuEnable !== 1'b1 || cpuDataIn !== 8'h5A || extRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_restart en=%b din=%h req=%b want 1/5a/0",
                     cpuEnable, cpuDataIn, extRequest);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_internal();
        test_external_read();
        test_external_write();
        test_timeout();
        test_external_only();
        test_halt();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
